// File: rtl/trackball_pkg.sv
// Shared constants for the PS/2-to-trackball quadrature generator: default
// accumulator width, bit positions inside trakball_o, and the clamp limit.
package trackball_pkg;

  localparam int ACC_W_DEF = 12;

  // trakball_o = {dirX,dirX,clkX,clkX,dirY,dirY,clkY,clkY}
  localparam int DIR_X_HI = 7;
  localparam int DIR_X_LO = 6;
  localparam int CLK_X_HI = 5;
  localparam int CLK_X_LO = 4;
  localparam int DIR_Y_HI = 3;
  localparam int DIR_Y_LO = 2;
  localparam int CLK_Y_HI = 1;
  localparam int CLK_Y_LO = 0;

  // Symmetric saturation magnitude for a signed accumulator of acc_w bits.
  function automatic int sat_limit(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/trackball_axis.sv
// One trackball axis: saturating signed motion accumulator drained one step
// per enabled tick, producing a direction bit and a toggling step clock.
module trackball_axis
  import trackball_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic signed [8:0] delta,
  input  logic              pkt,
  input  logic              tick,
  output logic              dir,
  output logic              step_clk
);

  // Two guard bits hold acc + delta +/- 1 without overflow before clamping.
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] LIM     = SUM_W'(sat_limit(ACC_W));
  localparam logic signed [SUM_W-1:0] NEG_LIM = -LIM;
  localparam logic signed [SUM_W-1:0] ONE     = SUM_W'(1);
  localparam logic signed [SUM_W-1:0] M_ONE   = SUM_W'(-1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [SUM_W-1:0] acc_ext;
  logic signed [SUM_W-1:0] delta_ext;
  logic signed [SUM_W-1:0] adj;
  logic signed [SUM_W-1:0] sum;
  logic                    moving;

  always_comb begin
    moving    = tick && (acc != '0);
    acc_ext   = {{2{acc[ACC_W-1]}}, acc};
    delta_ext = pkt ? {{(SUM_W-9){delta[8]}}, delta} : '0;
    adj       = '0;
    if (moving) adj = acc[ACC_W-1] ? ONE : M_ONE;
    sum       = acc_ext + delta_ext + adj;
    acc_next  = sum[ACC_W-1:0];
    if (sum > LIM)          acc_next = LIM[ACC_W-1:0];
    else if (sum < NEG_LIM) acc_next = NEG_LIM[ACC_W-1:0];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      dir      <= 1'b0;
      step_clk <= 1'b0;
    end else begin
      acc <= acc_next;
      if (moving) begin
        dir      <= ~acc[ACC_W-1];
        step_clk <= ~step_clk;
      end
    end
  end

endmodule

// File: rtl/trackball_quad_gen.sv
// Turns hps_io PS/2 mouse packets into Centipede trackball direction/clock
// pairs: toggle edge detect, flip handling, step divider and output packing.
module trackball_quad_gen
  import trackball_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter int STEP_DIV = 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [24:0] ps2_mouse,
  input  logic        flip,
  input  logic        hold,
  output logic [7:0]  trakball_o
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             tick_en;
  logic             primed;
  logic             toggle_q;
  logic             pkt;
  logic signed [8:0] delta_x;
  logic signed [8:0] delta_y;
  logic             dir_x, clk_x, dir_y, clk_y;
  logic             unused_bits;

  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:0]};

  // The divider free-runs; hold only masks the tick it produces.
  assign tick    = (div_cnt == DIV_LAST);
  assign tick_en = tick & ~hold;
  // No packet until the toggle copy has been loaded once after reset.
  assign pkt     = primed & (ps2_mouse[24] ^ toggle_q);
  assign delta_x = {ps2_mouse[4] ^ flip, ps2_mouse[15:8]};
  assign delta_y = {ps2_mouse[5] ^ flip, ps2_mouse[23:16]};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      primed   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= ps2_mouse[24];
      primed   <= 1'b1;
      div_cnt  <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  trackball_axis #(.ACC_W(ACC_W)) u_axis_x (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .delta    (delta_x),
    .pkt      (pkt),
    .tick     (tick_en),
    .dir      (dir_x),
    .step_clk (clk_x)
  );

  trackball_axis #(.ACC_W(ACC_W)) u_axis_y (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .delta    (delta_y),
    .pkt      (pkt),
    .tick     (tick_en),
    .dir      (dir_y),
    .step_clk (clk_y)
  );

  always_comb begin
    trakball_o                    = '0;
    trakball_o[DIR_X_HI:DIR_X_LO] = {2{dir_x}};
    trakball_o[CLK_X_HI:CLK_X_LO] = {2{clk_x}};
    trakball_o[DIR_Y_HI:DIR_Y_LO] = {2{dir_y}};
    trakball_o[CLK_Y_HI:CLK_Y_LO] = {2{clk_y}};
  end

endmodule

// File: tb/tb_trackball_quad_gen.sv
// Bench for trackball_quad_gen: one instance with STEP_DIV=1 and one with
// STEP_DIV=4 share stimulus and are checked every cycle against a model.
module tb_trackball_quad_gen;

  localparam int LIM = 2047;

  logic        clk_sys;
  logic        reset_n;
  logic [24:0] ps2_mouse;
  logic        flip;
  logic        hold;
  logic [7:0]  trak1;
  logic [7:0]  trak4;

  int checks = 0;
  int errors = 0;

  trackball_quad_gen #(.ACC_W(12), .STEP_DIV(1)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse),
    .flip(flip), .hold(hold), .trakball_o(trak1));

  trackball_quad_gen #(.ACC_W(12), .STEP_DIV(4)) dut4 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse),
    .flip(flip), .hold(hold), .trakball_o(trak4));

  // clock / reset
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // reference model: per instance, per axis integer motion totals
  int  divs [2] = '{1, 4};
  int  m_acc [2][2];
  bit  m_dir [2][2];
  bit  m_clk [2][2];
  bit  m_primed;
  bit  m_tog;
  int  m_n;

  function automatic int clampi(input int v);
    if (v > LIM)  return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 2; a++) begin
        m_acc[i][a] = 0; m_dir[i][a] = 0; m_clk[i][a] = 0;
      end
    m_primed = 0; m_tog = 0; m_n = 0;
  endtask

  task automatic model_step();
    bit pkt;
    if (!reset_n) return;
    pkt      = m_primed && (ps2_mouse[24] != m_tog);
    m_tog    = ps2_mouse[24];
    m_primed = 1;
    for (int i = 0; i < 2; i++) begin
      bit tick;
      tick = (m_n % divs[i]) == divs[i] - 1;
      for (int a = 0; a < 2; a++) begin
        int mag, d, s;
        bit sgn;
        mag = (a == 0) ? int'(ps2_mouse[15:8]) : int'(ps2_mouse[23:16]);
        sgn = (a == 0) ? ps2_mouse[4] : ps2_mouse[5];
        d = 0;
        if (pkt) d = (sgn ^ flip) ? mag - 256 : mag;
        s = 0;
        if (tick && !hold && m_acc[i][a] != 0) begin
          s = (m_acc[i][a] > 0) ? 1 : -1;
          m_dir[i][a] = (m_acc[i][a] > 0);
          m_clk[i][a] = ~m_clk[i][a];
        end
        m_acc[i][a] = clampi(m_acc[i][a] + d - s);
      end
    end
    m_n++;
  endtask

  function automatic logic [7:0] model_out(input int i);
    return {m_dir[i][0], m_dir[i][0], m_clk[i][0], m_clk[i][0],
            m_dir[i][1], m_dir[i][1], m_clk[i][1], m_clk[i][1]};
  endfunction

  // scoreboard helpers
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  logic [7:0] prev1, prev4;
  int cnt_x, cnt_y, cnt4_x, cyc_num;
  int t4_q[$];

  task automatic clear_counters();
    cnt_x = 0; cnt_y = 0; cnt4_x = 0; t4_q.delete();
  endtask

  task automatic check_outputs();
    chk8("trak_div1", trak1, model_out(0));
    chk8("trak_div4", trak4, model_out(1));
    if (trak1[5] != prev1[5]) cnt_x++;
    if (trak1[1] != prev1[1]) cnt_y++;
    if (trak4[5] != prev4[5]) begin
      cnt4_x++;
      t4_q.push_back(cyc_num);
    end
    prev1 = trak1;
    prev4 = trak4;
    cyc_num++;
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk8("reset_div1", trak1, 8'h00);
    chk8("reset_div4", trak4, 8'h00);
    prev1 = 8'h00; prev4 = 8'h00;
    run(2);
    reset_n = 1'b1;
    run(2);
    clear_counters();
  endtask

  task automatic send_pkt(input logic [7:0] xb, input logic xs,
                          input logic [7:0] yb, input logic ys);
    ps2_mouse[15:8]  = xb;
    ps2_mouse[23:16] = yb;
    ps2_mouse[4]     = xs;
    ps2_mouse[5]     = ys;
    ps2_mouse[24]    = ~ps2_mouse[24];
    cycle();
  endtask

  typedef struct {
    logic [7:0] xb; logic xs; logic [7:0] yb; logic ys; logic fl;
    int ex; int ey; logic edx; logic edy;
  } vec_t;

  vec_t vecs [6];
  logic [7:0] seq3 [4];

  initial begin
    vecs[0] = '{8'h03, 1'b0, 8'h00, 1'b0, 1'b0,   3,   0, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 8'hFE, 1'b1, 1'b0,   0,   2, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 8'hFE, 1'b1, 1'b1, 256, 254, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 256,   0, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 8'h01, 1'b1, 1'b0, 255, 255, 1'b1, 1'b0};
    vecs[5] = '{8'h05, 1'b1, 8'h00, 1'b1, 1'b1,   5,   0, 1'b1, 1'b0};
    seq3    = '{8'hF0, 8'hC0, 8'hF0, 8'hF0};

    ps2_mouse = 25'h0;
    ps2_mouse[24] = 1'b1;
    flip = 1'b0;
    hold = 1'b0;
    cyc_num = 0;

    // toggle high through reset: prime must not produce a packet
    do_reset();
    run(20);
    chk8("prime_idle", trak1, 8'h00);
    chk("prime_tog", cnt_x + cnt_y + cnt4_x, 0);

    // X +3, exact output sequence
    do_reset();
    send_pkt(8'h03, 1'b0, 8'h00, 1'b0);
    chk8("seq3_pkt_edge", trak1, 8'h00);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk8("seq3", trak1, seq3[k]);
    end

    // table-driven single packets
    foreach (vecs[i]) begin
      do_reset();
      flip = vecs[i].fl;
      send_pkt(vecs[i].xb, vecs[i].xs, vecs[i].yb, vecs[i].ys);
      run(300);
      chk("vec_x_toggles", cnt_x, vecs[i].ex);
      chk("vec_y_toggles", cnt_y, vecs[i].ey);
      chk("vec_dir_x", int'(prev1[7]), int'(vecs[i].edx));
      chk("vec_dir_y", int'(prev1[3]), int'(vecs[i].edy));
      flip = 1'b0;
    end

    // saturation: ten +255 packets while held, then drain
    do_reset();
    hold = 1'b1;
    for (int k = 0; k < 10; k++) send_pkt(8'hFF, 1'b0, 8'h00, 1'b0);
    hold = 1'b0;
    run(2100);
    chk("sat_toggles", cnt_x, 2047);
    chk("sat_dir", int'(prev1[7]), 1);

    // reset while the STEP_DIV=4 instance is still draining
    do_reset();
    run(20);
    chk("middrain_tog", cnt_x + cnt4_x, 0);
    chk8("middrain_o", trak4, 8'h00);

    // STEP_DIV=4 with hold for 20 cycles after a +5 packet
    do_reset();
    hold = 1'b1;
    send_pkt(8'h05, 1'b0, 8'h00, 1'b0);
    run(19);
    chk("hold_quiet", cnt4_x, 0);
    hold = 1'b0;
    run(40);
    chk("hold_total", cnt4_x, 5);
    for (int k = 1; k < t4_q.size(); k++)
      chk("hold_gap", t4_q[k] - t4_q[k-1], 4);

    // packet coinciding with a tick while acc = +2
    do_reset();
    hold = 1'b1;
    send_pkt(8'h02, 1'b0, 8'h00, 1'b0);
    hold = 1'b0;
    send_pkt(8'h01, 1'b0, 8'h00, 1'b0);
    chk("coinc_first", cnt_x, 1);
    chk8("coinc_o", trak1, 8'hF0);
    run(10);
    chk("coinc_total", cnt_x, 3);

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) flip = ~flip;
      if ($urandom_range(0, 3) == 0)
        send_pkt(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      else
        cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
